// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control unit.
// Steps each instruction through IF/ID/EXE/MEM/WB and decodes the current
// state, opcode and ALU zero flag into datapath enables and mux selects.
// Ports:
//   CLK, Reset     - clock (rising edge), asynchronous active-low reset
//   opcode, zero   - IR[31:26] (valid from ID onward), ALU result == 0
//   PCWre, IRWre, InsMemRW, mRD, mWR, RegWre - write/read enables
//   ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel, RegDst, PCSrc, ALUOp
//                  - datapath selects
//   state          - current FSM state, for debug
module multi_cycle_ctrl #(
  parameter int unsigned OPW    = 6,
  parameter int unsigned ALUOPW = 3
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  output logic              PCWre,
  output logic              IRWre,
  output logic              InsMemRW,
  output logic              mRD,
  output logic              mWR,
  output logic              RegWre,
  output logic              ALUSrcA,
  output logic              ALUSrcB,
  output logic              DBDataSrc,
  output logic              WrRegDSrc,
  output logic              ExtSel,
  output logic [1:0]        RegDst,
  output logic [1:0]        PCSrc,
  output logic [ALUOPW-1:0] ALUOp,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(6'b000001);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b010010);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b110000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b110001);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b110100);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b111000);
  localparam logic [OPW-1:0] OP_JR   = OPW'(6'b111001);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(6'b111010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(6'b111111);

  localparam logic [ALUOPW-1:0] ALU_ADD = ALUOPW'(3'b000);
  localparam logic [ALUOPW-1:0] ALU_SUB = ALUOPW'(3'b001);
  localparam logic [ALUOPW-1:0] ALU_OR  = ALUOPW'(3'b100);

  state_t cur_state;
  state_t nxt_state;

  // Opcode classes
  logic is_alu;
  logic is_ls;
  logic is_beq;
  logic is_jump;
  logic is_halt;

  assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_ORI);
  assign is_ls   = (opcode == OP_LW) || (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_jump = (opcode == OP_J) || (opcode == OP_JR) || (opcode == OP_JAL);
  assign is_halt = (opcode == OP_HALT);

  assign state = cur_state;

  // State register; reset forces IF without waiting for a clock
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cur_state <= S_IF;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state and output decode
  always_comb begin
    nxt_state = S_IF;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    RegWre    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    DBDataSrc = 1'b0;
    WrRegDSrc = 1'b0;
    ExtSel    = 1'b0;
    RegDst    = 2'b10;
    PCSrc     = 2'b00;
    ALUOp     = ALU_ADD;

    case (cur_state)
      S_IF: begin
        InsMemRW  = 1'b1;
        IRWre     = 1'b1;
        nxt_state = S_ID;
      end

      S_ID: begin
        if (is_alu) begin
          nxt_state = S_EXE_AL;
        end else if (is_ls) begin
          nxt_state = S_EXE_LS;
        end else if (is_beq) begin
          nxt_state = S_EXE_BR;
        end else if (is_halt) begin
          nxt_state = S_ID;
        end else begin
          // Jumps retire here; unknown opcodes retire as NOP
          nxt_state = S_IF;
          PCWre     = 1'b1;
          if (opcode == OP_J) begin
            PCSrc = 2'b11;
          end else if (opcode == OP_JR) begin
            PCSrc = 2'b10;
          end else if (opcode == OP_JAL) begin
            PCSrc     = 2'b11;
            RegWre    = 1'b1;
            RegDst    = 2'b00;
            WrRegDSrc = 1'b0;
          end
        end
      end

      S_EXE_AL, S_WB_AL: begin
        // ALU controls held through write-back so the result stays stable
        if (opcode == OP_SUB) begin
          ALUOp = ALU_SUB;
        end else if (opcode == OP_ORI) begin
          ALUOp = ALU_OR;
        end
        ALUSrcB   = (opcode == OP_ORI);
        RegDst    = (opcode == OP_ORI) ? 2'b01 : 2'b10;
        WrRegDSrc = 1'b1;
        if (cur_state == S_EXE_AL) begin
          nxt_state = S_WB_AL;
        end else begin
          RegWre    = 1'b1;
          PCWre     = 1'b1;
          nxt_state = S_IF;
        end
      end

      S_EXE_LS: begin
        ALUSrcB   = 1'b1;
        ExtSel    = 1'b1;
        nxt_state = S_MEM;
      end

      S_MEM: begin
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        if (opcode == OP_LW) begin
          mRD       = 1'b1;
          nxt_state = S_WB_LD;
        end else begin
          mWR       = (opcode == OP_SW);
          PCWre     = (opcode == OP_SW);
          nxt_state = S_IF;
        end
      end

      S_WB_LD: begin
        ALUSrcB   = 1'b1;
        ExtSel    = 1'b1;
        mRD       = 1'b1;
        DBDataSrc = 1'b1;
        WrRegDSrc = 1'b1;
        RegDst    = 2'b01;
        RegWre    = 1'b1;
        PCWre     = 1'b1;
        nxt_state = S_IF;
      end

      S_EXE_BR: begin
        // zero is only meaningful here, after the compare subtraction
        ALUOp     = ALU_SUB;
        ExtSel    = 1'b1;
        PCWre     = 1'b1;
        PCSrc     = zero ? 2'b01 : 2'b00;
        nxt_state = S_IF;
      end

      default: begin
        nxt_state = S_IF;
      end
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: a driver issues instructions (a
// directed prefix, then random opcodes, zero values and resets) and pushes the
// expected control word for every cycle; a monitor pops and compares at the
// falling edge.
module tb_multi_cycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwre;
    logic       irwre;
    logic       insmemrw;
    logic       mrd;
    logic       mwr;
    logic       regwre;
    logic       alusrca;
    logic       alusrcb;
    logic       dbdatasrc;
    logic       wrregdsrc;
    logic       extsel;
    logic [1:0] regdst;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
  } ctl_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam int NCYC  = 2000;
  localparam int NDIR  = 12;

  logic       CLK;
  logic       Reset;
  logic [5:0] opcode;
  logic       zero;
  logic       PCWre, IRWre, InsMemRW, mRD, mWR, RegWre;
  logic       ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp;
  logic [2:0] state;

  ctl_t got;
  ctl_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  multi_cycle_ctrl #(.OPW(6), .ALUOPW(3)) dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .mRD(mRD), .mWR(mWR),
    .RegWre(RegWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc), .ExtSel(ExtSel),
    .RegDst(RegDst), .PCSrc(PCSrc), .ALUOp(ALUOp), .state(state)
  );

  assign got = {state, PCWre, IRWre, InsMemRW, mRD, mWR, RegWre, ALUSrcA,
                ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel, RegDst, PCSrc, ALUOp};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Number of cycles an instruction occupies; 0 means it never finishes
  function automatic int instr_len(input logic [5:0] op);
    if (op inside {OP_ADD, OP_SUB, OP_ORI, OP_SW}) return 4;
    if (op == OP_LW)   return 5;
    if (op == OP_BEQ)  return 3;
    if (op == OP_HALT) return 0;
    return 2;
  endfunction

  // Expected control word for cycle 'step' of instruction 'op'
  function automatic ctl_t model(input logic [5:0] op, input int step, input logic z);
    ctl_t c;
    logic alu;
    logic ls;
    c = '0;
    c.regdst = 2'b10;
    alu = op inside {OP_ADD, OP_SUB, OP_ORI};
    ls  = op inside {OP_LW, OP_SW};
    if (step == 0) begin
      c.st = 3'd0; c.insmemrw = 1'b1; c.irwre = 1'b1;
      return c;
    end
    if (step == 1) begin
      c.st = 3'd1;
      if (op == OP_J) begin
        c.pcwre = 1'b1; c.pcsrc = 2'b11;
      end else if (op == OP_JR) begin
        c.pcwre = 1'b1; c.pcsrc = 2'b10;
      end else if (op == OP_JAL) begin
        c.pcwre = 1'b1; c.pcsrc = 2'b11; c.regwre = 1'b1; c.regdst = 2'b00;
      end else if (!alu && !ls && op != OP_BEQ && op != OP_HALT) begin
        c.pcwre = 1'b1;
      end
      return c;
    end
    if (alu) begin
      c.aluop = (op == OP_SUB) ? 3'b001 : ((op == OP_ORI) ? 3'b100 : 3'b000);
      c.alusrcb = (op == OP_ORI);
      c.regdst = (op == OP_ORI) ? 2'b01 : 2'b10;
      c.wrregdsrc = 1'b1;
      if (step == 2) begin
        c.st = 3'd6;
      end else begin
        c.st = 3'd7; c.regwre = 1'b1; c.pcwre = 1'b1;
      end
    end else if (ls) begin
      c.alusrcb = 1'b1; c.extsel = 1'b1;
      if (step == 2) begin
        c.st = 3'd2;
      end else if (step == 3) begin
        c.st = 3'd3; c.mrd = (op == OP_LW); c.mwr = (op == OP_SW); c.pcwre = (op == OP_SW);
      end else begin
        c.st = 3'd4; c.dbdatasrc = 1'b1; c.wrregdsrc = 1'b1; c.regdst = 2'b01;
        c.regwre = 1'b1; c.mrd = 1'b1; c.pcwre = 1'b1;
      end
    end else begin
      c.st = 3'd5; c.aluop = 3'b001; c.extsel = 1'b1; c.pcwre = 1'b1;
      c.pcsrc = z ? 2'b01 : 2'b00;
    end
    return c;
  endfunction

  // Driver state
  logic [5:0] dir_ops   [NDIR];
  int         dir_zero  [NDIR];
  int         di        = 0;
  logic [5:0] cur_op    = 6'd0;
  int         cur_zero  = -1;
  int         rst_step  = -1;
  int         step      = 0;
  int         halt_cnt  = 0;
  bit         in_reset  = 1'b0;

  task automatic pick_op();
    logic [5:0] r;
    if (di < NDIR) begin
      cur_op   = dir_ops[di];
      cur_zero = dir_zero[di];
      rst_step = (dir_ops[di] == OP_SW) ? 3 : -1;
      di++;
    end else begin
      cur_zero = -1;
      rst_step = -1;
      case ($urandom_range(0, 11))
        0: cur_op = OP_ADD;  1: cur_op = OP_SUB;  2: cur_op = OP_ORI;
        3: cur_op = OP_SW;   4: cur_op = OP_LW;   5: cur_op = OP_BEQ;
        6: cur_op = OP_BEQ;  7: cur_op = OP_J;    8: cur_op = OP_JR;
        9: cur_op = OP_JAL;
        10: cur_op = ($urandom_range(0, 3) == 0) ? OP_HALT : OP_LW;
        default: begin
          r = 6'($urandom_range(0, 63));
          while (r inside {OP_ADD, OP_SUB, OP_ORI, OP_SW, OP_LW, OP_BEQ,
                           OP_J, OP_JR, OP_JAL, OP_HALT})
            r = 6'($urandom_range(0, 63));
          cur_op = r;
        end
      endcase
    end
    opcode   = cur_op;
    halt_cnt = 0;
  endtask

  // Driver: one expected word per cycle, pushed just after the rising edge
  initial begin
    dir_ops  = '{OP_ADD, OP_LW, OP_BEQ, OP_BEQ, OP_JAL, OP_HALT, OP_SW,
                 6'b101010, OP_SUB, OP_ORI, OP_J, OP_JR};
    dir_zero = '{-1, -1, 1, 0, -1, -1, -1, -1, -1, -1, -1, -1};
    Reset  = 1'b1;
    opcode = 6'd0;
    zero   = 1'b0;
    #1 Reset = 1'b0;
    in_reset = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge CLK);
      #1;
      zero = 1'($urandom);
      if (in_reset) begin
        // Reset still low across this edge: state is IF, release afterwards
        pick_op();
        exp_q.push_back(model(cur_op, 0, zero));
        #1 Reset = 1'b1;
        in_reset = 1'b0;
        step = 1;
      end else begin
        if (step == 0) pick_op();
        if (cur_zero >= 0) zero = (cur_zero != 0);
        if ((step == rst_step) || (halt_cnt >= 10) ||
            (di >= NDIR && $urandom_range(0, 29) == 0)) begin
          // Asynchronous reset mid-cycle: outputs must already show IF
          exp_q.push_back(model(cur_op, 0, zero));
          #1 Reset = 1'b0;
          in_reset = 1'b1;
          halt_cnt = 0;
          step = 0;
        end else begin
          exp_q.push_back(model(cur_op, step, zero));
          if (instr_len(cur_op) == 0) begin
            if (step == 0) step = 1;
            else halt_cnt++;
          end else begin
            step = (step + 1 == instr_len(cur_op)) ? 0 : step + 1;
          end
        end
      end
    end
    @(negedge CLK);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Monitor: compare the presented control word at each falling edge
  int mcyc = 0;
  initial begin
    ctl_t e;
    forever begin
      @(negedge CLK);
      mcyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (got === e) begin
          n_pass++;
        end else begin
          $display("FAIL ctl cycle=%0d opcode=%b zero=%b Reset=%b got=%h required=%h",
                   mcyc, opcode, zero, Reset, got, e);
        end
      end
    end
  end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Multi-cycle CPU control unit: a Moore/Mealy FSM that steps each instruction through IF/ID/EXE/MEM/WB.
- Drives every datapath write enable and every mux select:
  - 2:1 32-bit muxes
  - 3:1 5-bit register-destination mux
  - 4:1 32-bit PC-source mux
- Sits between the instruction register (opcode) and the ALU zero flag on one side, and the datapath on the other.

Parameters:
- OPW, 6, opcode width.
- ALUOPW, 3, ALU operation code width.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset; 0 forces state IF immediately.
- opcode  input  OPW  IR[31:26]; valid from ID onward.
- zero  input  1  ALU result == 0.
- PCWre  output  1  PC register write enable.
- IRWre  output  1  instruction register write enable.
- InsMemRW  output  1  instruction memory read enable.
- mRD  output  1  data memory read.
- mWR  output  1  data memory write.
- RegWre  output  1  register file write enable.
- ALUSrcA  output  1  2:1 select: 0=rs data, 1=shamt.
- ALUSrcB  output  1  2:1 select: 0=rt data, 1=extended immediate.
- DBDataSrc  output  1  2:1 select: 0=ALU result, 1=memory data.
- WrRegDSrc  output  1  2:1 select: 0=PC+4 (JAL link), 1=DB data.
- ExtSel  output  1  0=zero-extend, 1=sign-extend.
- RegDst  output  2  3:1 select: 00=$31, 01=rt, 10=rd.
- PCSrc  output  2  4:1 select: 00=PC+4, 01=branch target, 10=rs, 11=jump target.
- ALUOp  output  ALUOPW  000=add, 001=sub, 100=or.
- state  output  3  current state, for debug/verification.

Behaviour:
- State encoding:
  - IF=000, ID=001, EXE_LS=010, MEM=011, WB_LD=100, EXE_BR=101, EXE_AL=110, WB_AL=111, HALT=stays ID (no separate code).
- Opcodes:
  - ADD=000000, SUB=000001, ORI=010010
  - SW=110000, LW=110001, BEQ=110100
  - J=111000, JR=111001, JAL=111010, HALT=111111
- Transitions:
  - IF->ID always.
  - ID:
    - ADD/SUB/ORI->EXE_AL
    - LW/SW->EXE_LS
    - BEQ->EXE_BR
    - J/JR/JAL->IF
    - HALT->ID
    - unknown opcode->IF (executed as NOP)
  - EXE_AL->WB_AL->IF.
  - EXE_LS->MEM.
  - MEM: SW->IF, LW->WB_LD.
  - WB_LD->IF.
  - EXE_BR->IF.
  - Illegal state code->IF.
- Outputs are combinational from (state, opcode, zero).
  - Default for all outputs is 0, with RegDst=10 and PCSrc=00 unless listed below.
- IF: InsMemRW=1, IRWre=1.
- PCWre=1 only in the last state of each instruction:
  - WB_AL, WB_LD, EXE_BR, SW-MEM
  - ID for J/JR/JAL/unknown
  - Never in HALT.
  - Gives exactly one PC update per instruction.
- PCSrc:
  - J=11, JAL=11, JR=10
  - EXE_BR: 01 if zero=1, else 00
  - otherwise 00
- JAL in ID: RegWre=1, RegDst=00, WrRegDSrc=0.
- ALU-class instructions, asserted in both EXE_AL and WB_AL:
  - ALUOp: ADD=000, SUB=001, ORI=100.
  - ALUSrcB=1 and ExtSel=0 for ORI.
  - RegDst: 01 for ORI, 10 for ADD/SUB.
  - WrRegDSrc=1, DBDataSrc=0.
  - RegWre=1 in WB_AL only.
- LW/SW, in EXE_LS/MEM/WB_LD: ALUSrcB=1, ExtSel=1, ALUOp=000.
  - MEM: mRD=1 for LW, mWR=1 for SW.
  - WB_LD: DBDataSrc=1, WrRegDSrc=1, RegDst=01, RegWre=1, mRD=1.
- EXE_BR: ALUOp=001, ExtSel=1, ALUSrcB=0.
- HALT: all enables 0, PCWre=0; FSM remains in ID until Reset.
- Reset asserted mid-instruction:
  - State goes to IF asynchronously; write enables are removed in the same delta.
  - After release, the first rising edge moves IF->ID.
- zero is sampled only in EXE_BR; it is ignored elsewhere.

Test Plan:
- Reset=0 in any state -> state=000, PCWre=RegWre=mWR=0, IRWre=1. Release, one CLK -> state=001.
- opcode=000000 (ADD) -> state sequence 000,001,110,111,000. RegWre=1 and PCWre=1 only in 111, with RegDst=10, ALUOp=000.
- opcode=110001 (LW) -> sequence 000,001,010,011,100,000. mRD=1 in 011 and 100. RegWre=1, DBDataSrc=1, RegDst=01 in 100. Total 5 cycles.
- opcode=110100 (BEQ): zero=1 -> in state 101, PCSrc=01, PCWre=1. zero=0 -> PCSrc=00. Both cases return to 000 next cycle.
- opcode=111010 (JAL) -> in 001: PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0, PCWre=1; next state 000. opcode=111111 (HALT) -> state holds 001 for 10 cycles, PCWre=0.
- SW with Reset pulled low during MEM -> mWR drops to 0 immediately and state=000. Unknown opcode 101010 -> ID->IF, PCWre=1, no RegWre/mWR.
